// File: rtl/substitution_layer_iter.sv
// ---------------------------------------------------------------------------
// substitution_layer_iter
//
// Iterative ASCON substitution layer. Applies the 5-bit ASCON S-box to all
// 64 bit-columns of the 320-bit permutation state, NUM_SBOX columns per
// clock. Sits between constant addition and linear diffusion.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. o_ready and o_valid are decoded from the FSM state only, so they
// never depend combinationally on i_valid or i_ready. o_state is stable while
// o_valid is high and the result has not been taken.
//
// Ports:
//   clock     in   1    system clock, rising edge
//   reset_n   in   1    asynchronous active-low reset
//   i_clear   in   1    synchronous abort back to IDLE (register is held)
//   i_valid   in   1    upstream state valid
//   o_ready   out  1    block can accept a state (IDLE only)
//   i_state   in   320  input state, word xk = i_state[64k+63:64k]
//   o_valid   out  1    substituted state available (DONE only)
//   i_ready   in   1    downstream accepts the result
//   o_state   out  320  substituted state, same packing as i_state
//   o_busy    out  1    high while columns are being substituted
// ---------------------------------------------------------------------------
module substitution_layer_iter #(
    parameter int NUM_SBOX = 8
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         i_clear,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [319:0] i_state,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [319:0] o_state,
    output logic         o_busy
);

    localparam int NUM_ITER = 64 / NUM_SBOX;
    localparam int CNT_W    = (NUM_ITER > 1) ? $clog2(NUM_ITER) : 1;
    localparam int GRP_SH   = $clog2(NUM_SBOX);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_ITER - 1);

    // Only power-of-two group sizes tile the 64 columns exactly.
    generate
        if (!(NUM_SBOX == 1  || NUM_SBOX == 2  || NUM_SBOX == 4 ||
              NUM_SBOX == 8  || NUM_SBOX == 16 || NUM_SBOX == 32 ||
              NUM_SBOX == 64)) begin : g_bad_num_sbox
            $error("substitution_layer_iter: NUM_SBOX must be 1,2,4,8,16,32 or 64");
        end
    endgenerate

    // Word k of the state is data[k]; column j of word k is data[k][j].
    typedef logic [4:0][63:0] state_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } fsm_t;

    fsm_t             fsm_q, fsm_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    state_t           data_q, data_d;

    logic [5:0]                    grp_base;
    logic [NUM_SBOX-1:0][5:0]      col;
    logic [NUM_SBOX-1:0][4:0]      sb_in;
    logic [NUM_SBOX-1:0][4:0]      sb_out;
    state_t                        data_sub;

    function automatic logic [4:0] sbox5(input logic [4:0] x);
        logic [4:0] y;
        case (x)
            5'h00: y = 5'h04;  5'h01: y = 5'h0b;  5'h02: y = 5'h1f;  5'h03: y = 5'h14;
            5'h04: y = 5'h1a;  5'h05: y = 5'h15;  5'h06: y = 5'h09;  5'h07: y = 5'h02;
            5'h08: y = 5'h1b;  5'h09: y = 5'h05;  5'h0a: y = 5'h08;  5'h0b: y = 5'h12;
            5'h0c: y = 5'h1d;  5'h0d: y = 5'h03;  5'h0e: y = 5'h06;  5'h0f: y = 5'h1c;
            5'h10: y = 5'h1e;  5'h11: y = 5'h13;  5'h12: y = 5'h07;  5'h13: y = 5'h0e;
            5'h14: y = 5'h00;  5'h15: y = 5'h0d;  5'h16: y = 5'h11;  5'h17: y = 5'h18;
            5'h18: y = 5'h10;  5'h19: y = 5'h0c;  5'h1a: y = 5'h01;  5'h1b: y = 5'h19;
            5'h1c: y = 5'h16;  5'h1d: y = 5'h0a;  5'h1e: y = 5'h0f;  default: y = 5'h17;
        endcase
        return y;
    endfunction

    // First column of the active group. NUM_SBOX is a power of two, so the
    // group offset is a shift and the low GRP_SH bits are always zero.
    assign grp_base = 6'(cnt_q) << GRP_SH;

    for (genvar s = 0; s < NUM_SBOX; s++) begin : g_sbox
        assign col[s]    = grp_base | 6'(s);
        // x0 is the MSB of the S-box input.
        assign sb_in[s]  = {data_q[0][col[s]], data_q[1][col[s]], data_q[2][col[s]],
                            data_q[3][col[s]], data_q[4][col[s]]};
        assign sb_out[s] = sbox5(sb_in[s]);
    end

    // Register image with the active group replaced; other columns hold.
    always_comb begin
        data_sub = data_q;
        for (int s = 0; s < NUM_SBOX; s++) begin
            data_sub[0][col[s]] = sb_out[s][4];
            data_sub[1][col[s]] = sb_out[s][3];
            data_sub[2][col[s]] = sb_out[s][2];
            data_sub[3][col[s]] = sb_out[s][1];
            data_sub[4][col[s]] = sb_out[s][0];
        end
    end

    always_comb begin
        fsm_d  = fsm_q;
        cnt_d  = cnt_q;
        data_d = data_q;
        if (i_clear) begin
            // Abort wins over every transition; the register keeps its value.
            fsm_d = ST_IDLE;
            cnt_d = '0;
        end else begin
            case (fsm_q)
                ST_IDLE: begin
                    if (i_valid) begin
                        data_d = i_state;
                        cnt_d  = '0;
                        fsm_d  = ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    data_d = data_sub;
                    if (cnt_q == CNT_LAST) begin
                        cnt_d = '0;
                        fsm_d = ST_DONE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    if (i_ready) begin
                        fsm_d = ST_IDLE;
                    end
                end
                default: begin
                    fsm_d = ST_IDLE;
                    cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fsm_q  <= ST_IDLE;
            cnt_q  <= '0;
            data_q <= '0;
        end else begin
            fsm_q  <= fsm_d;
            cnt_q  <= cnt_d;
            data_q <= data_d;
        end
    end

    assign o_ready = (fsm_q == ST_IDLE);
    assign o_valid = (fsm_q == ST_DONE);
    assign o_busy  = (fsm_q == ST_BUSY);
    assign o_state = data_q;

endmodule

// File: doc/substitution_layer_iter.md
Name: substitution_layer_iter

Overview:
- Parametrised, iterative ASCON substitution layer; successor of the single 5-bit S-box.
- Applies the ASCON 5-bit S-box to all 64 bit-columns of the 320-bit permutation state, NUM_SBOX columns per clock, using NUM_SBOX instantiated S-box lookups.
- Sits in the permutation datapath between constant addition and linear diffusion.
- Valid/ready handshakes on both sides, so area/throughput is tuned by one parameter.

Parameters:
- NUM_SBOX, 8: S-boxes evaluated per cycle. Legal values are 1, 2, 4, 8, 16, 32, 64; any other value fails elaboration.
- NUM_ITER, 64/NUM_SBOX (derived, not overridable): cycles per state.
- CNT_W, max(1, clog2(NUM_ITER)) (derived): column-group counter width.

Ports:
- clock  input  1  system clock, rising edge
- reset_n  input  1  asynchronous active-low reset
- i_clear  input  1  synchronous abort; returns the block to IDLE
- i_valid  input  1  upstream state valid
- o_ready  output  1  block can accept a state
- i_state  input  320  input state; word xk = i_state[64k+63:64k], k=0..4
- o_valid  output  1  substituted state available
- i_ready  input  1  downstream accepts the result
- o_state  output  320  substituted state, same word packing as i_state
- o_busy  output  1  high in BUSY state

Behaviour:
- Column j (0..63): S-box input = {x0[j],x1[j],x2[j],x3[j],x4[j]}, x0 is the MSB. Output bits map back the same way.
- S-box table, index 0..31: 04 0b 1f 14 1a 15 09 02 1b 05 08 12 1d 03 06 1c 1e 13 07 0e 00 0d 11 18 10 0c 01 19 16 0a 0f 17 (hex).
- Internal 320-bit state register plus CNT_W-bit group counter cnt.
- FSM states: IDLE, BUSY, DONE.
- Reset (reset_n low, asynchronous):
  - state = IDLE, cnt = 0, state register = 0.
  - o_ready = 1, o_valid = 0, o_busy = 0, o_state = 0.
- IDLE:
  - o_ready = 1.
  - i_valid & o_ready at an edge: i_state is captured, cnt = 0, move to BUSY.
- BUSY:
  - o_ready = 0, o_busy = 1.
  - Each cycle, columns [cnt*NUM_SBOX +: NUM_SBOX] of the register are replaced by their S-box outputs; all other columns hold; cnt increments.
  - When cnt == NUM_ITER-1, that final group is written and the FSM moves to DONE.
  - i_valid is ignored.
- DONE:
  - o_valid = 1; o_state = register, stable until handshake.
  - o_valid & i_ready at an edge: move to IDLE.
  - o_ready = 0 in DONE. There is no same-cycle re-accept; a new state is taken the cycle after returning to IDLE.
- Latency: accept at edge t, o_valid high after edge t+NUM_ITER. Throughput is one state per NUM_ITER+2 cycles with i_ready tied high.
- NUM_SBOX = 64: BUSY lasts exactly one cycle; the counter is unused and the wrap test is trivially true.
- o_state is driven only from the register. Partial values are visible while BUSY but carry no meaning; o_valid = 0 during BUSY.
- i_clear: takes priority over every transition, from any state. Next edge gives IDLE, cnt = 0, o_valid = 0; the register is held.
- i_valid and i_clear high together in IDLE: the clear wins and nothing is captured.
- reset_n asserted mid-BUSY: immediate return to reset values, with no partial output.
- Counter wrap: cnt returns to 0 on DONE entry. It never exceeds NUM_ITER-1.
- No combinational path from i_valid/i_ready to o_ready/o_valid; all of these are decoded from FSM state only.

Test Plan:
- All-zero state, NUM_SBOX=8:
  - i_valid pulse -> o_valid rises exactly 8 cycles after accept.
  - o_state: x2 = FFFF_FFFF_FFFF_FFFF; x0, x1, x3, x4 = 0 (each column maps 0x00 -> 0x04).
- All-ones state, NUM_SBOX=1 and NUM_SBOX=64:
  - o_state: x0, x2, x3, x4 = all ones; x1 = 0 (0x1f -> 0x17).
  - Latency is 64 and 1 cycles respectively.
- Column walk:
  - x0..x4 set so column j carries value j mod 32.
  - Every output column must equal the table entry; compare against the golden model for all 7 NUM_SBOX values.
- Backpressure:
  - i_ready held low 10 cycles in DONE -> o_valid and o_state stable; o_ready = 0 throughout.
  - i_ready high -> IDLE next cycle; a second state is accepted the following edge.
- Abort:
  - i_clear at cycle 3 of BUSY -> IDLE next edge, o_valid never asserted.
  - A fresh all-zero state afterwards gives the correct result.
- Async reset:
  - reset_n dropped mid-BUSY, asynchronous to clock -> o_ready = 1, o_valid = 0, o_busy = 0, o_state = 0 immediately.
  - Normal operation resumes after release.
